firing_control: RTL and testbench

- Control FSM that drives the 3-bit `control` bus of the firing datapath, which holds the 2-bit remaining-shot count.
- Converts the raw trigger button into debounced shot events, enforces a cooldown between shots, and sequences the three shots per round.
- Generates the datapath's active-low reset so a new round reloads the datapath to 3 shots.
- Sits between the trigger input pin and the firing datapath; its status outputs feed game logic.

---
 rtl/firing_control.sv | 182 ++++++++++++++++++
 tb/tb_firing_control.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/firing_control.sv
// -----------------------------------------------------------------------------
// firing_control
//
// Control FSM for the firing datapath. Turns the raw, bouncy trigger button
// into clean one-cycle press events, enforces a cooldown between shots,
// sequences the three shots of a round, and generates the datapath's
// active-low reset so a reload puts the datapath back to three shots.
//
// The state code is driven straight onto `control`:
//   READY3=000 FIRE1=001 READY2=010 FIRE2=011 READY1=100 FIRE3=101 EMPTY=110
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles the synchronized trigger must differ
//                    from the debounced level before the level flips (>= 1)
//   COOLDOWN_CYCLES  cycles after a shot during which presses are discarded
//   CNT_W            width of the debounce and cooldown counters
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   trigger_raw  asynchronous bouncy trigger button, 1 = pressed
//   reload       one-cycle request to start a new round
//   control      datapath command / state code
//   dp_reset_n   active-low reset to the firing datapath
//   shot_fired   high during each FIRE state (one cycle per accepted shot)
//   dry_fire     one-cycle pulse for a press while out of ammo
//   out_of_ammo  high in EMPTY
//   busy         high while the cooldown counter is nonzero
// -----------------------------------------------------------------------------
module firing_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COOLDOWN_CYCLES = 8,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger_raw,
  input  logic       reload,
  output logic [2:0] control,
  output logic       dp_reset_n,
  output logic       shot_fired,
  output logic       dry_fire,
  output logic       out_of_ammo,
  output logic       busy
);

  typedef enum logic [2:0] {
    READY3 = 3'b000,
    FIRE1  = 3'b001,
    READY2 = 3'b010,
    FIRE2  = 3'b011,
    READY1 = 3'b100,
    FIRE3  = 3'b101,
    EMPTY  = 3'b110,
    UNUSED = 3'b111
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES);

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer, counting debouncer, press edge pulse
  // ---------------------------------------------------------------------------
  logic             sync1;
  logic             sync2;
  logic             deb_level;
  logic             press;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] deb_cnt_inc;

  assign deb_cnt_inc = deb_cnt + ONE;

  // NOTE: every flop here is written with <= so all registers see the values
  // from before the edge; blocking assignments would let sync2 pick up the
  // new sync1 in the same edge and silently remove a synchronizer stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= trigger_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt_inc == DEB_LIMIT) begin
        // Level has disagreed long enough: accept it. Only the rising edge
        // of the debounced level is a press; release produces nothing.
        deb_level <= ~deb_level;
        deb_cnt   <= '0;
        press     <= ~deb_level;
      end else begin
        deb_cnt <= deb_cnt_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cool_cnt;
  logic [CNT_W-1:0] cool_next;
  logic             dp_rst_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= READY3;
      cool_cnt    <= '0;
      dp_rst_pend <= 1'b1;
    end else begin
      state       <= state_next;
      cool_cnt    <= cool_next;
      // Datapath reset is low for exactly the cycle in which READY3 first
      // shows after a reload.
      dp_rst_pend <= reload;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and cooldown counter
  // ---------------------------------------------------------------------------
  // NOTE: both outputs of this block get a default before any branch, so no
  // path leaves them unassigned and no latch can be inferred.
  always_comb begin
    state_next = state;
    cool_next  = (cool_cnt != '0) ? cool_cnt - ONE : '0;

    if (reload) begin
      // Reload wins over a simultaneous press and over a shot in progress.
      state_next = READY3;
      cool_next  = '0;
    end else begin
      case (state)
        READY3: if (press && cool_cnt == '0) state_next = FIRE1;
        READY2: if (press && cool_cnt == '0) state_next = FIRE2;
        READY1: if (press && cool_cnt == '0) state_next = FIRE3;
        FIRE1: begin
          state_next = READY2;
          cool_next  = COOL_LOAD;
        end
        FIRE2: begin
          state_next = READY1;
          cool_next  = COOL_LOAD;
        end
        FIRE3: begin
          state_next = EMPTY;
          cool_next  = COOL_LOAD;
        end
        EMPTY:   state_next = EMPTY;
        default: state_next = READY3;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    control     = state;
    shot_fired  = 1'b0;
    dry_fire    = 1'b0;
    out_of_ammo = 1'b0;
    busy        = (cool_cnt != '0);
    dp_reset_n  = ~dp_rst_pend;
    case (state)
      FIRE1, FIRE2, FIRE3: shot_fired = 1'b1;
      EMPTY: begin
        out_of_ammo = 1'b1;
        // A press dropped by a simultaneous reload is not a dry fire either.
        dry_fire    = press & ~reload;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_firing_control.sv
// -----------------------------------------------------------------------------
// tb_firing_control
//
// Two instances: defaults (debounce 4, cooldown 8) and the boundary corner
// (debounce 1, no cooldown), driven by the same inputs. A behavioural model
// tracks shots taken, whether a shot is in flight, and remaining cooldown for
// each instance; a compare process checks every output each cycle. A directed
// timeline with hand-computed literal expectations runs first, then random
// trigger/reload/reset traffic.
// -----------------------------------------------------------------------------
module tb_firing_control;

  logic       clk;
  logic       reset;
  logic       trigger_raw;
  logic       reload;
  logic [2:0] ctrl     [2];
  logic       dpn      [2];
  logic       shot     [2];
  logic       dry      [2];
  logic       ooa      [2];
  logic       bsy      [2];

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  firing_control #(.DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(8), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .trigger_raw(trigger_raw), .reload(reload),
    .control(ctrl[0]), .dp_reset_n(dpn[0]), .shot_fired(shot[0]),
    .dry_fire(dry[0]), .out_of_ammo(ooa[0]), .busy(bsy[0])
  );

  firing_control #(.DEBOUNCE_CYCLES(1), .COOLDOWN_CYCLES(0), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .trigger_raw(trigger_raw), .reload(reload),
    .control(ctrl[1]), .dp_reset_n(dpn[1]), .shot_fired(shot[1]),
    .dry_fire(dry[1]), .out_of_ammo(ooa[1]), .busy(bsy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a round is "shots taken so far" plus "a shot is being
  // fired right now"; the control code is simply 2*shots + firing.
  // ---------------------------------------------------------------------------
  int dbn   [2] = '{4, 1};
  int cdn   [2] = '{8, 0};
  bit m_s1  [2];
  bit m_s2  [2];
  bit m_deb [2];
  int m_run [2];
  bit m_press [2];
  int m_shots [2];
  bit m_firing[2];
  int m_cool  [2];
  bit m_dprst [2] = '{1'b1, 1'b1};
  int dp_cnt  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0; m_press[i] = 0;
        m_shots[i] = 0; m_firing[i] = 0; m_cool[i] = 0; m_dprst[i] = 1;
      end else begin
        bit new_press;
        if (reload) begin
          m_shots[i] = 0; m_firing[i] = 0; m_cool[i] = 0;
        end else if (m_firing[i]) begin
          m_firing[i] = 0;
          m_shots[i]  = m_shots[i] + 1;
          m_cool[i]   = cdn[i];
        end else begin
          if (m_press[i] && m_shots[i] < 3 && m_cool[i] == 0) m_firing[i] = 1;
          if (m_cool[i] > 0) m_cool[i] = m_cool[i] - 1;
        end
        m_dprst[i] = reload;
        // Debounced level follows the synchronized input once it has stayed
        // different for the required run of consecutive samples.
        new_press = 0;
        if (m_s2[i] != m_deb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == dbn[i]) begin
            m_deb[i]  = !m_deb[i];
            m_run[i]  = 0;
            new_press = m_deb[i];
          end
        end else begin
          m_run[i] = 0;
        end
        m_press[i] = new_press;
        m_s2[i] = m_s1[i];
        m_s1[i] = trigger_raw;
      end
    end
  end

  // Remaining-shot datapath driven by the DUT's control bus and reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dpn[i] === 1'b0) dp_cnt[i] = 3;
      else if (ctrl[i] === 3'b001 || ctrl[i] === 3'b011 || ctrl[i] === 3'b101)
        dp_cnt[i] = dp_cnt[i] - 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d control", i), 32'(ctrl[i]), 32'(2 * m_shots[i] + int'(m_firing[i])));
        check($sformatf("u%0d shot_fired", i), 32'(shot[i]), 32'(m_firing[i]));
        check($sformatf("u%0d out_of_ammo", i), 32'(ooa[i]), 32'(m_shots[i] == 3 && !m_firing[i]));
        check($sformatf("u%0d dry_fire", i), 32'(dry[i]),
              32'(m_shots[i] == 3 && !m_firing[i] && m_press[i] && !reload));
        check($sformatf("u%0d busy", i), 32'(bsy[i]), 32'(m_cool[i] != 0));
        check($sformatf("u%0d dp_reset_n", i), 32'(dpn[i]), 32'(!m_dprst[i]));
        if (!m_dprst[i])
          check($sformatf("u%0d dp count", i), 32'(dp_cnt[i]), 32'(3 - m_shots[i]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed trigger schedule, indexed by the clock edge that samples it
  // (edge 1 is the first edge after reset is released).
  // ---------------------------------------------------------------------------
  function automatic logic trig_at(input int n);
    if (n <= 4)   return 1'b1;
    if (n <= 8)   return 1'b0;
    if (n <= 12)  return 1'b1;  // re-press lands during cooldown
    if (n <= 20)  return 1'b0;
    if (n <= 24)  return 1'b1;  // FIRE2
    if (n <= 32)  return 1'b0;
    if (n <= 36)  return 1'b1;  // FIRE3 -> EMPTY
    if (n <= 44)  return 1'b0;
    if (n <= 48)  return 1'b1;  // dry fire
    if (n <= 56)  return 1'b0;
    if (n <= 60)  return 1'b1;  // FIRE1 of new round
    if (n <= 68)  return 1'b0;
    if (n <= 72)  return 1'b1;  // press coincident with reload
    if (n <= 80)  return 1'b0;
    if (n <= 84)  return 1'b1;  // FIRE1, then reset mid-cooldown
    if (n <= 91)  return 1'b0;
    if (n <= 111) return (((n - 92) / 2) % 2 == 0);  // bounce every 2 cycles
    return 1'b1;
  endfunction

  initial begin
    int  bounce_shots;
    bit  trig_val;
    int  hold;
    bounce_shots = 0;
    trig_val     = 1'b0;
    hold         = 0;
    reset        = 1'b1;
    trigger_raw  = 1'b0;
    reload       = 1'b0;

    tick();
    checking = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("reset control", 32'(ctrl[0]), 32'h0);
    check("reset dp_reset_n", 32'(dpn[0]), 32'h0);
    check("reset busy", 32'(bsy[0]), 32'h0);
    check("reset shot_fired", 32'(shot[0]), 32'h0);
    check("reset out_of_ammo", 32'(ooa[0]), 32'h0);
    tick();

    for (int n = 1; n <= 125; n++) begin
      trigger_raw = trig_at(n);
      reload      = (n == 53) || (n == 75);
      reset       = (n == 90);
      tick();
      @(negedge clk);
      if (n >= 92 && shot[0] === 1'b1) bounce_shots++;
      case (n)
        6:   check("held: control before edge 7", 32'(ctrl[0]), 32'h0);
        7: begin
          check("held: FIRE1 at edge 7", 32'(ctrl[0]), 32'h1);
          check("held: shot_fired at edge 7", 32'(shot[0]), 32'h1);
        end
        8: begin
          check("held: READY2 after FIRE1", 32'(ctrl[0]), 32'h2);
          check("held: count 2", 32'(dp_cnt[0]), 32'd2);
          check("held: busy after shot", 32'(bsy[0]), 32'h1);
        end
        15: begin
          check("cooldown: press discarded", 32'(ctrl[0]), 32'h2);
          check("cooldown: busy", 32'(bsy[0]), 32'h1);
        end
        16:  check("cooldown: busy falls", 32'(bsy[0]), 32'h0);
        27:  check("FIRE2 code", 32'(ctrl[0]), 32'h3);
        28:  check("count 1 after FIRE2", 32'(dp_cnt[0]), 32'd1);
        39:  check("FIRE3 code", 32'(ctrl[0]), 32'h5);
        40: begin
          check("EMPTY code", 32'(ctrl[0]), 32'h6);
          check("EMPTY out_of_ammo", 32'(ooa[0]), 32'h1);
          check("EMPTY count 0", 32'(dp_cnt[0]), 32'd0);
          check("model shots after FIRE3", 32'(m_shots[0]), 32'd3);
        end
        50: begin
          check("dry_fire pulse", 32'(dry[0]), 32'h1);
          check("dry_fire stays EMPTY", 32'(ctrl[0]), 32'h6);
        end
        51: begin
          check("dry_fire one cycle", 32'(dry[0]), 32'h0);
          check("still EMPTY", 32'(ctrl[0]), 32'h6);
        end
        53: begin
          check("reload: READY3", 32'(ctrl[0]), 32'h0);
          check("reload: dp_reset_n low", 32'(dpn[0]), 32'h0);
          check("reload: out_of_ammo clear", 32'(ooa[0]), 32'h0);
        end
        54: begin
          check("reload: dp_reset_n one cycle", 32'(dpn[0]), 32'h1);
          check("reload: count 3", 32'(dp_cnt[0]), 32'd3);
        end
        63:  check("new round FIRE1", 32'(ctrl[0]), 32'h1);
        75: begin
          check("reload+press: READY3", 32'(ctrl[0]), 32'h0);
          check("reload+press: no shot", 32'(shot[0]), 32'h0);
          check("reload+press: dp_reset_n low", 32'(dpn[0]), 32'h0);
        end
        76: begin
          check("reload+press: press dropped", 32'(ctrl[0]), 32'h0);
          check("reload+press: still no shot", 32'(shot[0]), 32'h0);
        end
        89:  check("pre-reset busy", 32'(bsy[0]), 32'h1);
        90: begin
          check("mid-cooldown reset control", 32'(ctrl[0]), 32'h0);
          check("mid-cooldown reset busy", 32'(bsy[0]), 32'h0);
          check("mid-cooldown reset dp_reset_n", 32'(dpn[0]), 32'h0);
        end
        91:  check("after reset count 3", 32'(dp_cnt[0]), 32'd3);
        117: check("bounce: no shot before stable", 32'(ctrl[0]), 32'h0);
        118: check("bounce: FIRE1 after 4 stable", 32'(ctrl[0]), 32'h1);
        default: ;
      endcase
    end
    check("bounce: exactly one shot", 32'(bounce_shots), 32'd1);

    // Random traffic: trigger held for random runs (short runs act as bounce),
    // occasional reloads and resets.
    reset  = 1'b0;
    reload = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        trig_val = ~trig_val;
        hold     = int'($urandom_range(1, 10));
      end
      hold        = hold - 1;
      trigger_raw = trig_val;
      reload      = ($urandom_range(0, 39) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
